// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: per-cycle stall/flush/enable sequencer for a 5-stage
// RISC-V core. It resolves load-use hazards, EX redirects, data-memory waits
// and HALT. A HALT drains the pipe and then parks the core.
//
// Memory handshake: mem_req is the MEM stage's request and is held stable
// until the cycle in which mem_ready is high. That cycle completes the access.
// A cycle with mem_req=1 and mem_ready=0 is a wait cycle and freezes the core.
// mem_ready is ignored whenever mem_req is low, except in MEM_WAIT, where only
// mem_ready decides whether the access has completed.
//
// dbg_state encoding: 0=RUN, 1=MEM_WAIT, 2=DRAIN, 3=HALTED.
module pipeline_sequencer #(
  parameter int DRAIN_CYCLES = 3,
  parameter int MEM_TIMEOUT  = 16,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_halt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pipe_en,
  output logic             halted,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_count,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_DRAIN    = 2'd2,
    S_HALTED   = 2'd3
  } state_t;

  localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam int WW = (MEM_TIMEOUT < 3) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES);
  // The wait counter holds the number of wait cycles already seen, so a
  // timeout fires on the wait cycle in which it equals MEM_TIMEOUT-1.
  localparam logic [WW-1:0] WAIT_LAST  = WW'(MEM_TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [DW-1:0]    r_drain_cnt;
  logic [DW-1:0]    w_next_drain;
  logic [WW-1:0]    r_wait_cnt;
  logic [WW-1:0]    w_next_wait;
  logic             r_halted;
  logic             r_mem_error;
  logic [CNT_W-1:0] r_stall_count;

  logic w_freeze;
  logic w_load_use;
  logic w_advance;
  logic w_timeout;
  logic w_pc_write;
  logic w_ifid_write;
  logic w_ifid_flush;
  logic w_idex_flush;
  logic w_pipe_en;

  assign w_freeze   = mem_req & ~mem_ready;
  assign w_load_use = ex_memread & (ex_rd != 5'd0) &
                      ((id_use_rs1 & (id_rs1 == ex_rd)) |
                       (id_use_rs2 & (id_rs2 == ex_rd)));
  // In RUN a new wait starts on freeze. In MEM_WAIT only completion matters.
  assign w_advance  = (r_state == S_MEM_WAIT) ? mem_ready : ~w_freeze;

  // Next-state, counter updates and combinational control outputs.
  always_comb begin
    w_next_state = r_state;
    w_next_drain = r_drain_cnt;
    w_next_wait  = r_wait_cnt;
    w_timeout    = 1'b0;
    w_pc_write   = 1'b1;
    w_ifid_write = 1'b1;
    w_ifid_flush = 1'b0;
    w_idex_flush = 1'b0;
    w_pipe_en    = 1'b1;
    if (reset) begin
      w_pc_write   = 1'b0;
      w_ifid_write = 1'b0;
      w_pipe_en    = 1'b0;
      w_ifid_flush = 1'b1;
      w_idex_flush = 1'b1;
      w_next_state = S_RUN;
      w_next_drain = '0;
      w_next_wait  = '0;
    end else begin
      case (r_state)
        S_RUN, S_MEM_WAIT: begin
          if (!w_advance) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_pipe_en    = 1'b0;
            if (r_state == S_RUN) begin
              w_next_state = S_MEM_WAIT;
              w_next_wait  = WW'(1);
            end else if (r_wait_cnt == WAIT_LAST) begin
              w_next_state = S_HALTED;
              w_timeout    = 1'b1;
            end else begin
              w_next_wait = r_wait_cnt + 1'b1;
            end
          end else begin
            w_next_state = S_RUN;
            w_next_wait  = '0;
            if (ex_redirect) begin
              // The ID instruction is killed, so a hazard or HALT in ID is moot.
              w_ifid_flush = 1'b1;
              w_idex_flush = 1'b1;
            end else if (w_load_use) begin
              w_pc_write   = 1'b0;
              w_ifid_write = 1'b0;
              w_idex_flush = 1'b1;
            end else if (id_halt) begin
              // HALT moves into EX and then behaves as a bubble while the older work drains.
              w_pc_write   = 1'b0;
              w_ifid_write = 1'b0;
              w_next_state = S_DRAIN;
              w_next_drain = DRAIN_INIT;
            end
          end
        end
        S_DRAIN: begin
          w_pc_write   = 1'b0;
          w_ifid_write = 1'b0;
          w_idex_flush = 1'b1;
          w_pipe_en    = ~w_freeze;
          if (w_freeze) begin
            if (r_wait_cnt == WAIT_LAST) begin
              w_next_state = S_HALTED;
              w_timeout    = 1'b1;
            end else begin
              w_next_wait = r_wait_cnt + 1'b1;
            end
          end else begin
            w_next_wait = '0;
            if (r_drain_cnt != '0) begin
              w_next_drain = r_drain_cnt - 1'b1;
            end
            if (r_drain_cnt <= DW'(1)) begin
              w_next_state = S_HALTED;
            end
          end
        end
        default: begin
          w_pc_write   = 1'b0;
          w_ifid_write = 1'b0;
          w_pipe_en    = 1'b0;
        end
      endcase
    end
  end

  // State and progress counters. Reset discards any DRAIN or MEM_WAIT progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_RUN;
      r_drain_cnt <= '0;
      r_wait_cnt  <= '0;
    end else begin
      r_state     <= w_next_state;
      r_drain_cnt <= w_next_drain;
      r_wait_cnt  <= w_next_wait;
    end
  end

  // Sticky status flags and the saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_halted      <= 1'b0;
      r_mem_error   <= 1'b0;
      r_stall_count <= '0;
    end else begin
      if (w_next_state == S_HALTED) begin
        r_halted <= 1'b1;
      end
      if (w_timeout) begin
        r_mem_error <= 1'b1;
      end
      if (!w_pc_write && (r_state != S_HALTED) && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + 1'b1;
      end
    end
  end

  assign pc_write    = w_pc_write;
  assign ifid_write  = w_ifid_write;
  assign ifid_flush  = w_ifid_flush;
  assign idex_flush  = w_idex_flush;
  assign pipe_en     = w_pipe_en;
  assign halted      = r_halted;
  assign mem_error   = r_mem_error;
  assign stall_count = r_stall_count;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer: vector table, directed corner sequences and random
// stimulus against a counting reference model of the sequencer.
module tb_pipeline_sequencer;

  localparam int DRAIN_CYCLES = 3;
  localparam int MEM_TIMEOUT  = 4;
  localparam int CNT_W        = 5;
  localparam int STALL_MAX    = (1 << CNT_W) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             id_use_rs1, id_use_rs2, id_halt, ex_memread, ex_redirect;
  logic             mem_req, mem_ready;
  logic             pc_write, ifid_write, ifid_flush, idex_flush, pipe_en;
  logic             halted, mem_error;
  logic [CNT_W-1:0] stall_count;
  logic [1:0]       dbg_state;

  always #5 clk = ~clk;

  pipeline_sequencer #(
    .DRAIN_CYCLES(DRAIN_CYCLES),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .id_halt    (id_halt),
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .ex_redirect(ex_redirect),
    .mem_req    (mem_req),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .ifid_write (ifid_write),
    .ifid_flush (ifid_flush),
    .idex_flush (idex_flush),
    .pipe_en    (pipe_en),
    .halted     (halted),
    .mem_error  (mem_error),
    .stall_count(stall_count),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] ctrl_now();
    return {pc_write, ifid_write, ifid_flush, idex_flush, pipe_en};
  endfunction

  // ---------------- reference model ----------------
  // It tracks only counts: the drain cycles still owed, the consecutive wait
  // cycles seen, the stall total, and the sticky flags.
  bit         m_halted, m_err;
  int         m_drain, m_wait, m_stall;
  logic [4:0] e_ctrl;
  bit         e_halted, e_err;
  int         e_stall;

  task automatic model_cycle();
    bit lu, fr, stuck;
    e_halted = m_halted;
    e_err    = m_err;
    e_stall  = m_stall;
    lu = ex_memread && (ex_rd != 0) &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    fr = mem_req && !mem_ready;
    if (reset) begin
      e_ctrl   = 5'b00110;
      m_halted = 0; m_err = 0; m_stall = 0; m_drain = 0; m_wait = 0;
    end else if (m_halted) begin
      e_ctrl = 5'b00000;
    end else if (m_drain > 0) begin
      e_ctrl = {4'b0001, !fr};
      if (fr) begin
        m_wait++;
        if (m_wait == MEM_TIMEOUT) begin m_halted = 1; m_err = 1; end
      end else begin
        m_wait = 0;
        m_drain--;
        if (m_drain == 0) m_halted = 1;
      end
    end else begin
      stuck = (m_wait > 0) ? !mem_ready : fr;
      if (stuck) begin
        e_ctrl = 5'b00000;
        m_wait++;
        if (m_wait == MEM_TIMEOUT) begin m_halted = 1; m_err = 1; end
      end else begin
        m_wait = 0;
        if (ex_redirect)  e_ctrl = 5'b11111;
        else if (lu)      e_ctrl = 5'b00011;
        else if (id_halt) begin e_ctrl = 5'b00001; m_drain = DRAIN_CYCLES; end
        else              e_ctrl = 5'b11001;
      end
    end
    if (!reset && !e_halted && !e_ctrl[4] && m_stall < STALL_MAX) m_stall++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_halt = 0;
    ex_memread = 0; ex_rd = 0; ex_redirect = 0; mem_req = 0; mem_ready = 0;
  endtask

  // Run the model for the current inputs and compare outputs on the falling edge.
  task automatic eval_and_check(input string tag);
    model_cycle();
    @(negedge clk);
    check({tag, ".ctrl"},  32'(ctrl_now()),  32'(e_ctrl));
    check({tag, ".halt"},  32'(halted),      32'(e_halted));
    check({tag, ".err"},   32'(mem_error),   32'(e_err));
    check({tag, ".stall"}, 32'(stall_count), 32'(e_stall));
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag);
    eval_and_check(tag);
    advance();
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1;
    step("reset");
    reset = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [4:0] rs1, rs2;
    logic       use1, use2, halt, memread;
    logic [4:0] rd;
    logic       redirect, req, rdy;
    logic [4:0] ctrl;    // {pc_write, ifid_write, ifid_flush, idex_flush, pipe_en}
    logic [1:0] nstate;  // state after the clock edge
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  int req_hold;
  int halted_for;

  initial begin
    vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b11001, 2'd0};
    vecs[1]  = '{5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 5'b00011, 2'd0};
    vecs[2]  = '{5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'b11001, 2'd0};
    vecs[3]  = '{5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 5'b00011, 2'd0};
    vecs[4]  = '{5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 5'b11001, 2'd0};
    vecs[5]  = '{5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 5'b11001, 2'd0};
    vecs[6]  = '{5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 5'b11111, 2'd0};
    vecs[7]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00001, 2'd2};
    vecs[8]  = '{5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 5'b00011, 2'd0};
    vecs[9]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 5'b00000, 2'd1};
    vecs[10] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'b00001, 2'd2};
    vecs[11] = '{5'd4, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1, 1'b1, 5'b11001, 2'd0};
    vecs[12] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 5'b11111, 2'd0};

    m_halted = 0; m_err = 0; m_drain = 0; m_wait = 0; m_stall = 0;
    set_idle();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;

    // Reset state.
    do_reset();
    check("reset.state", 32'(dbg_state), 32'd0);

    // Single-cycle vectors, each from a fresh RUN state.
    for (int v = 0; v < NV; v++) begin
      do_reset();
      id_rs1 = vecs[v].rs1; id_rs2 = vecs[v].rs2;
      id_use_rs1 = vecs[v].use1; id_use_rs2 = vecs[v].use2;
      id_halt = vecs[v].halt; ex_memread = vecs[v].memread; ex_rd = vecs[v].rd;
      ex_redirect = vecs[v].redirect; mem_req = vecs[v].req; mem_ready = vecs[v].rdy;
      eval_and_check($sformatf("vec%0d", v));
      check($sformatf("vec%0d.tbl_ctrl", v), 32'(ctrl_now()), 32'(vecs[v].ctrl));
      advance();
      check($sformatf("vec%0d.next_state", v), 32'(dbg_state), 32'(vecs[v].nstate));
      check($sformatf("vec%0d.stall_after", v), 32'(stall_count), vecs[v].ctrl[4] ? 32'd0 : 32'd1);
    end

    // The stall lasts exactly one cycle once the hazard leaves EX.
    do_reset();
    ex_memread = 1; ex_rd = 5; id_use_rs2 = 1; id_rs2 = 5;
    step("lu.hit");
    set_idle();
    step("lu.after");
    check("lu.count", 32'(stall_count), 32'd1);

    // A three-cycle memory wait is followed by a ready cycle.
    do_reset();
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) step("mw.wait");
    mem_ready = 1;
    eval_and_check("mw.ready");
    check("mw.ready_pipe_en", 32'(pipe_en), 32'd1);
    advance();
    set_idle();
    check("mw.state", 32'(dbg_state), 32'd0);
    check("mw.count", 32'(stall_count), 32'd3);

    // Memory timeout: HALTED follows the fourth wait cycle.
    do_reset();
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 4; i++) step("to.wait");
    check("to.state", 32'(dbg_state), 32'd3);
    check("to.halted", 32'(halted), 32'd1);
    check("to.err", 32'(mem_error), 32'd1);
    for (int i = 0; i < 3; i++) step("to.frozen");

    // HALT drains for three cycles and then stays halted.
    do_reset();
    id_halt = 1;
    step("dr.halt");
    id_halt = 0;
    for (int i = 0; i < DRAIN_CYCLES; i++) begin
      check("dr.not_yet", 32'(halted), 32'd0);
      step("dr.drain");
    end
    check("dr.halted", 32'(halted), 32'd1);
    for (int i = 0; i < 12; i++) begin
      ex_redirect = 1'($urandom_range(0, 1)); id_halt = 1'($urandom_range(0, 1));
      step("dr.sticky");
    end
    check("dr.still_halted", 32'(halted), 32'd1);

    // A two-cycle freeze inside DRAIN delays HALTED by two cycles.
    do_reset();
    id_halt = 1;
    step("df.halt");
    id_halt = 0;
    step("df.d1");
    mem_req = 1; mem_ready = 0;
    step("df.f1");
    step("df.f2");
    mem_ready = 1;
    step("df.d2");
    set_idle();
    check("df.not_yet", 32'(halted), 32'd0);
    step("df.d3");
    check("df.halted", 32'(halted), 32'd1);

    // Reset during the second DRAIN cycle discards the drain.
    do_reset();
    id_halt = 1;
    step("rd.halt");
    set_idle();
    step("rd.d1");
    reset = 1;
    step("rd.reset");
    reset = 0;
    check("rd.state", 32'(dbg_state), 32'd0);
    check("rd.halted", 32'(halted), 32'd0);
    check("rd.count", 32'(stall_count), 32'd0);
    eval_and_check("rd.run");
    check("rd.pc_write", 32'(pc_write), 32'd1);
    advance();

    // The stall counter saturates at all-ones.
    do_reset();
    ex_memread = 1; ex_rd = 3; id_use_rs1 = 1; id_rs1 = 3;
    for (int i = 0; i < STALL_MAX + 8; i++) step("sat");
    check("sat.count", 32'(stall_count), 32'(STALL_MAX));

    // Random stimulus; mem_req stays high until mem_ready completes it.
    do_reset();
    req_hold = 0;
    halted_for = 0;
    for (int c = 0; c < 1500; c++) begin
      reset       = (halted_for > 6) || ($urandom_range(0, 99) == 0);
      id_rs1      = 5'($urandom_range(0, 7));
      id_rs2      = 5'($urandom_range(0, 7));
      id_use_rs1  = 1'($urandom_range(0, 1));
      id_use_rs2  = 1'($urandom_range(0, 1));
      id_halt     = ($urandom_range(0, 29) == 0);
      ex_memread  = ($urandom_range(0, 2) == 0);
      ex_rd       = 5'($urandom_range(0, 7));
      ex_redirect = ($urandom_range(0, 5) == 0);
      if (req_hold == 0) mem_req = ($urandom_range(0, 3) == 0);
      mem_ready   = mem_req ? 1'($urandom_range(0, 1)) : 1'b0;
      step("rand");
      req_hold   = (mem_req && !mem_ready && !reset) ? 1 : 0;
      halted_for = m_halted ? halted_for + 1 : 0;
    end
    reset = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
